// File: rtl/demux_stage1to2.sv
// rtl/demux_stage1to2.sv - registered 1-to-2 routing stage with one FIFO per output channel
// Optional accepted-word counters (count0_o/count1_o) are built when DEMUX_STAGE_STATS_EN is defined.
module demux_stage1to2 #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] in_i,
    input  logic         sel_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [N-1:0] out0_o,
    output logic [N-1:0] out1_o,
    output logic         out0_valid_o,
    output logic         out1_valid_o,
    input  logic         out0_ready_i,
    input  logic         out1_ready_i
`ifdef DEMUX_STAGE_STATS_EN
    ,
    output logic [31:0]  count0_o,
    output logic [31:0]  count1_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [N-1:0]  mem0_q [DEPTH];
    logic [N-1:0]  mem1_q [DEPTH];

    logic [PW-1:0] wr0_q, wr0_d, rd0_q, rd0_d;
    logic [PW-1:0] wr1_q, wr1_d, rd1_q, rd1_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic push0, push1, pop0, pop1;

    // Acceptance looks only at registered occupancy, never at the consumer readies.
    assign in_ready_o   = !reset_i && ((sel_i ? cnt1_q : cnt0_q) != CW'(DEPTH));
    assign push0        = in_valid_i && in_ready_o && !sel_i;
    assign push1        = in_valid_i && in_ready_o && sel_i;

    assign out0_valid_o = (cnt0_q != '0);
    assign out1_valid_o = (cnt1_q != '0);
    assign pop0         = out0_valid_o && out0_ready_i;
    assign pop1         = out1_valid_o && out1_ready_i;

    assign out0_o       = out0_valid_o ? mem0_q[rd0_q] : '0;
    assign out1_o       = out1_valid_o ? mem1_q[rd1_q] : '0;

    always_comb begin
        wr0_d  = wr0_q + PW'(push0);
        rd0_d  = rd0_q + PW'(pop0);
        cnt0_d = cnt0_q + CW'(push0) - CW'(pop0);
        wr1_d  = wr1_q + PW'(push1);
        rd1_d  = rd1_q + PW'(pop1);
        cnt1_d = cnt1_q + CW'(push1) - CW'(pop1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr0_q  <= '0;
            rd0_q  <= '0;
            cnt0_q <= '0;
            wr1_q  <= '0;
            rd1_q  <= '0;
            cnt1_q <= '0;
        end else begin
            wr0_q  <= wr0_d;
            rd0_q  <= rd0_d;
            cnt0_q <= cnt0_d;
            wr1_q  <= wr1_d;
            rd1_q  <= rd1_d;
            cnt1_q <= cnt1_d;
        end
    end

    // Storage is left uncleared on reset; the occupancy counters mask stale entries.
    always_ff @(posedge clk_i) begin
        if (push0) mem0_q[wr0_q] <= in_i;
        if (push1) mem1_q[wr1_q] <= in_i;
    end

`ifdef DEMUX_STAGE_STATS_EN
    logic [31:0] stat0_q, stat0_d, stat1_q, stat1_d;

    always_comb begin
        stat0_d = stat0_q + 32'(push0);
        stat1_d = stat1_q + 32'(push1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign count0_o = stat0_q;
    assign count1_o = stat1_q;
`endif

endmodule
